aes_key_expander: RTL
=====================

# aes_key_expander

Iterative AES key-schedule engine for 128/192/256-bit keys. It accepts one cipher key per request and streams all Nr+1 round keys (11/13/15) as 128-bit words through a valid/ready output port. Word-serial generation shares one 32-bit S-box. It sits between key storage and the AES round datapath, replacing per-round subkey generation that supported only 128-bit keys and had no flow control.

## Interface
- KEY_LEN, 128, cipher key width; legal values are 128, 192 and 256 (Nk = KEY_LEN/32, Nr = Nk+6).
- WORD_LEN, 32, key-schedule word width; fixed at 32.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  reset is synchronous and active-high.
- key_in  in  KEY_LEN  cipher key; bits [KEY_LEN-1 -: 32] hold w[0].
- key_valid  in  1  key request.
- key_ready  out  1  high only in IDLE.
- rk_data  out  128  round key; [127:96] = w[4r] … [31:0] = w[4r+3].
- rk_round  out  4  round index r of rk_data.
- rk_last  out  1  high with rk_valid when r = Nr.
- rk_valid  out  1  rk_data, rk_round and rk_last are valid.
- rk_ready  in  1  consumer accepts the key when rk_valid && rk_ready.
- busy  out  1  high from key acceptance until the last key is accepted.

## Operation
- Reset values: key_ready=1, rk_valid=0, rk_last=0, busy=0, rk_data=0, rk_round=0. All internal state is cleared.
- Key acceptance: on key_valid && key_ready, key_in is latched and the FSM leaves IDLE. While busy, key_valid is ignored.
- Word generation, i = Nk … 4(Nr+1)-1:
  - Default: w[i] = w[i-Nk] ^ temp, with temp = w[i-1].
  - If i mod Nk = 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon, 24'h0}.
  - If Nk = 8 and i mod Nk = 4: temp = SubWord(w[i-1]).
- Rcon starts at 8'h01 and advances by xtime (multiply by x in GF(2^8), reduction polynomial 8'h1B) after each use. Required sequence: 01 02 04 08 10 20 40 80 1B 36.
- Storage:
  - A sliding window holds the last Nk words.
  - A 4-word assembly register collects w[4r..4r+3].
  - An output holding register drives rk_*.
- FSM states:
  - IDLE: key_ready=1.
  - LOAD: appends key words w[0..Nk-1] to the assembly register, one per cycle.
  - SUB: presents the S-box input, even when temp needs no substitution; every generated word costs 2 cycles.
  - COMBINE: XORs and appends w[i]; goes to SUB if words remain, else DRAIN.
  - DRAIN: waits for the final round key to be accepted, then returns to IDLE.
- Handover: a full assembly register moves to the output register when !rk_valid || rk_ready. That same cycle rk_round increments, from 0 after the key starts.
- Backpressure: LOAD and COMBINE must not append while the assembly register is full and handover is blocked. The FSM holds its state and no words are lost.
- Simultaneous events: accept plus handover in the same cycle gives a continuous stream with no bubble. When the last key is accepted: busy drops, and key_ready rises in the next cycle.
- Reset mid-operation: the run is aborted with no partial output. The block restarts only on a new key request.

## Timing
- Reference point: E0 is the edge that accepts the key.
- Key word w[j] is appended at edge E(j+1).
- Generated word w[i] is appended at edge E(Nk + 2(i-Nk+1)).
- Round key r asserts rk_valid after the edge that follows the append of w[4r+3], provided rk_ready stays high.
- Resulting schedule with no backpressure:
  - KEY_LEN=128: r=0 valid after E5, r=1 after E13, r=10 after E85.
  - KEY_LEN=256: r=14 valid after E113.
- S-box latency is exactly 1 cycle (registered output).
- The outputs are registered; there is no combinational path from rk_ready or key_valid to any output.

## Structure
- Shared package aes_pkg holds:
  - constants AES_WORD_LEN=32 and AES_BLOCK_LEN=128;
  - function nk_of(KEY_LEN) and function nr_of(KEY_LEN);
  - function xtime;
  - the FSM state enum.
- Sub-module aes_subword: four byte S-boxes with a registered 32-bit output, sync active-high reset, and ports clk, reset, in_word, out_word.
- KEY_LEN is checked at elaboration time. Any value other than 128, 192 or 256 is a fatal error.

## Test plan
- FIPS-197 A.1, 128-bit key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1:
  - r=1 = a0fafe17 88542cb1 23a33939 2a6c7605;
  - r=10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, with rk_last=1;
  - cycle counts exactly as in Timing.
- FIPS-197 A.2, 192-bit key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - 13 keys are output;
  - r=12 = e98ba06f 448c773c 8ecc7204 01002202.
- FIPS-197 A.3, 256-bit key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - r=14 = fe4890d1 e6188d0b 046df344 706c631e;
  - rk_last=1 with r=14 only.
- Random rk_ready, 30% low, 128-bit vector:
  - all 11 keys in order, none dropped or duplicated;
  - rk_data stable while rk_valid && !rk_ready.
- key_valid pulsed while busy:
  - ignored, key_ready=0, output unaffected.
  - A new key issued one cycle after the last acceptance starts a fresh correct run.
- reset asserted mid-run, after r=4:
  - next cycle rk_valid=0, busy=0, key_ready=1;
  - a subsequent A.1 run reproduces the exact A.1 results.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block widths, key-length helpers,
// GF(2^8) doubling and the key-expander FSM state encoding.
package aes_pkg;

  localparam int AES_WORD_LEN  = 32;
  localparam int AES_BLOCK_LEN = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SUB     = 3'd2,
    COMBINE = 3'd3,
    DRAIN   = 3'd4
  } kx_state_e;

  // Number of 32-bit words in the cipher key.
  function automatic int nk_of(input int key_len);
    return key_len / AES_WORD_LEN;
  endfunction

  // Number of rounds; the schedule produces nr_of()+1 round keys.
  function automatic int nr_of(input int key_len);
    return nk_of(key_len) + 6;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Four AES byte S-boxes with a registered 32-bit output (1-cycle latency).
// Each S-box is computed as the GF(2^8) inverse followed by the affine map.
module aes_subword
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] sub_d;
  logic [31:0] sub_q;

  // Substitute all four bytes of the presented word.
  always_comb begin
    sub_d = {sbox_byte(in_word[31:24]), sbox_byte(in_word[23:16]),
             sbox_byte(in_word[15:8]),  sbox_byte(in_word[7:0])};
  end

  // Register the substituted word.
  always_ff @(posedge clk) begin
    if (reset) sub_q <= '0;
    else       sub_q <= sub_d;
  end

  assign out_word = sub_q;

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule for 128/192/256-bit keys. Words are produced
// one at a time through a shared registered S-box (SUB then COMBINE per word),
// packed four at a time and streamed out as 128-bit round keys.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// key_valid/key_ready: key_ready is high only in IDLE; key_in is sampled on
// the accepting edge and key_valid is ignored otherwise. rk_valid/rk_ready:
// once rk_valid rises, rk_data/rk_round/rk_last hold until the edge where
// rk_ready is also high. No output depends combinationally on any input.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int KEY_LEN  = 128,
  parameter int WORD_LEN = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [KEY_LEN-1:0]       key_in,
  input  logic                     key_valid,
  output logic                     key_ready,
  output logic [AES_BLOCK_LEN-1:0] rk_data,
  output logic [3:0]               rk_round,
  output logic                     rk_last,
  output logic                     rk_valid,
  input  logic                     rk_ready,
  output logic                     busy,
  output logic [2:0]               state_dbg
);

  localparam int         NK          = nk_of(KEY_LEN);
  localparam int         NR          = nr_of(KEY_LEN);
  localparam int         TOTAL_WORDS = 4 * (NR + 1);
  localparam logic [3:0] LAST_ROUND  = 4'(NR);
  localparam logic [2:0] NK_LAST     = 3'(NK - 1);
  localparam logic [5:0] FIRST_GEN   = 6'(NK);
  localparam logic [5:0] LAST_WORD   = 6'(TOTAL_WORDS - 1);

  if (!(KEY_LEN == 128 || KEY_LEN == 192 || KEY_LEN == 256)) begin : g_bad_key_len
    $fatal(1, "aes_key_expander: KEY_LEN must be 128, 192 or 256");
  end
  if (WORD_LEN != AES_WORD_LEN) begin : g_bad_word_len
    $fatal(1, "aes_key_expander: WORD_LEN must be 32");
  end

  kx_state_e    state_q;
  logic [31:0]  win_q [NK];     // win_q[0] = w[i-Nk] ... win_q[NK-1] = w[i-1]
  logic [31:0]  asm_q [4];      // asm_q[0] is the oldest word of the round key
  logic [2:0]   asm_cnt_q;
  logic [2:0]   load_cnt_q;
  logic [5:0]   word_idx_q;     // index i of the word being generated
  logic [2:0]   mod_q;          // i mod Nk
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic [127:0] rk_data_q;
  logic [3:0]   rk_round_q;
  logic         rk_last_q;
  logic         rk_valid_q;
  logic         busy_q;
  logic         key_ready_q;

  logic         asm_full;
  logic         handover;
  logic         can_append;
  logic         last_accept;
  logic         key_accept;
  logic         append_en;
  logic [31:0]  append_word;
  logic         is_rot;
  logic         is_sub4;
  logic [31:0]  w_prev;
  logic [31:0]  w_old;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic [31:0]  temp;
  logic [31:0]  w_new;

  aes_subword u_subword (
    .clk      (clk),
    .reset    (reset),
    .in_word  (sbox_in),
    .out_word (sbox_out)
  );

  // Flow control: handover frees the assembly register, appends wait for room.
  always_comb begin
    asm_full    = (asm_cnt_q == 3'd4);
    handover    = asm_full && (!rk_valid_q || rk_ready);
    can_append  = !asm_full || handover;
    last_accept = rk_valid_q && rk_ready && rk_last_q;
    key_accept  = (state_q == IDLE) && key_valid;
    append_en   = 1'b0;
    append_word = w_new;
    case (state_q)
      LOAD: begin
        append_en   = can_append;
        append_word = win_q[0];
      end
      COMBINE: append_en = can_append;
      default: append_en = 1'b0;
    endcase
  end

  // Next schedule word; the S-box input is held steady while COMBINE stalls.
  always_comb begin
    w_prev  = win_q[NK-1];
    w_old   = win_q[0];
    is_rot  = (mod_q == 3'd0);
    is_sub4 = (NK == 8) && (mod_q == 3'd4);
    sbox_in = is_rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    if (is_rot)       temp = sbox_out ^ {rcon_q, 24'h0};
    else if (is_sub4) temp = sbox_out;
    else              temp = w_prev;
    w_new = w_old ^ temp;
  end

  // Assembly shift register and output holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) asm_q[k] <= '0;
      asm_cnt_q  <= '0;
      round_q    <= '0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rk_last_q  <= 1'b0;
      rk_valid_q <= 1'b0;
    end else begin
      if (append_en) begin
        for (int k = 0; k < 3; k++) asm_q[k] <= asm_q[k+1];
        asm_q[3] <= append_word;
      end
      if (handover)       asm_cnt_q <= append_en ? 3'd1 : 3'd0;
      else if (append_en) asm_cnt_q <= asm_cnt_q + 3'd1;
      if (handover) begin
        rk_data_q  <= {asm_q[0], asm_q[1], asm_q[2], asm_q[3]};
        rk_round_q <= round_q;
        rk_last_q  <= (round_q == LAST_ROUND);
        rk_valid_q <= 1'b1;
        round_q    <= round_q + 4'd1;
      end else if (rk_valid_q && rk_ready) begin
        rk_valid_q <= 1'b0;
        rk_last_q  <= 1'b0;
      end
      if (key_accept) round_q <= '0;
    end
  end

  // Control FSM: load key words, then SUB/COMBINE per generated word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
      load_cnt_q  <= '0;
      word_idx_q  <= '0;
      mod_q       <= '0;
      rcon_q      <= '0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            for (int k = 0; k < NK; k++)
              win_q[k] <= key_in[KEY_LEN-1-AES_WORD_LEN*k -: AES_WORD_LEN];
            load_cnt_q  <= '0;
            word_idx_q  <= FIRST_GEN;
            mod_q       <= '0;
            rcon_q      <= 8'h01;
            busy_q      <= 1'b1;
            key_ready_q <= 1'b0;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          // Rotate the window so after Nk appends it holds w[0..Nk-1] again.
          if (can_append) begin
            for (int k = 0; k < NK-1; k++) win_q[k] <= win_q[k+1];
            win_q[NK-1] <= win_q[0];
            if (load_cnt_q == NK_LAST) state_q <= SUB;
            else                       load_cnt_q <= load_cnt_q + 3'd1;
          end
        end
        SUB: state_q <= COMBINE;
        COMBINE: begin
          if (can_append) begin
            for (int k = 0; k < NK-1; k++) win_q[k] <= win_q[k+1];
            win_q[NK-1] <= w_new;
            if (is_rot) rcon_q <= xtime(rcon_q);
            mod_q <= (mod_q == NK_LAST) ? 3'd0 : mod_q + 3'd1;
            if (word_idx_q == LAST_WORD) begin
              state_q <= DRAIN;
            end else begin
              word_idx_q <= word_idx_q + 6'd1;
              state_q    <= SUB;
            end
          end
        end
        DRAIN: begin
          if (last_accept) begin
            busy_q      <= 1'b0;
            key_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ready = key_ready_q;
  assign rk_data   = rk_data_q;
  assign rk_round  = rk_round_q;
  assign rk_last   = rk_last_q;
  assign rk_valid  = rk_valid_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule
